// File: rtl/wb_counter_pkg.sv
// Shared register map, control bit positions and byte-lane helpers for the
// Wishbone up/down counter bank.
package wb_counter_pkg;

    localparam logic [3:0] CTRL_OFS   = 4'h0;
    localparam logic [3:0] COUNT_OFS  = 4'h4;
    localparam logic [3:0] LIMIT_OFS  = 4'h8;
    localparam logic [3:0] STATUS_OFS = 4'hC;

    localparam int EN_B    = 0;
    localparam int UP_B    = 1;
    localparam int WRAP_B  = 2;
    localparam int IRQEN_B = 3;
    localparam int TC_B    = 0;

    localparam int CH_STRIDE = 16;

    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
        logic [31:0] m;
        m = lane_mask(sel);
        return (old_v & ~m) | (new_v & m);
    endfunction

endpackage

// File: rtl/wb_counter_bank_channel.sv
// One counter channel: CTRL/COUNT/LIMIT/STATUS registers, next-count logic
// and the one-cycle terminal-count pulse.
module counter_channel
    import wb_counter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick_i,
    input  logic             wr_ctrl_i,
    input  logic             wr_count_i,
    input  logic             wr_limit_i,
    input  logic             wr_status_i,
    input  logic [31:0]      wdata_i,
    input  logic [3:0]       wsel_i,
    output logic [3:0]       ctrl_o,
    output logic [WIDTH-1:0] count_o,
    output logic [WIDTH-1:0] limit_o,
    output logic             tc_flag_o,
    output logic             tc_o
);

    logic [3:0]       ctrl_q, ctrl_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             flag_q, flag_d;
    logic             tc_q;
    logic             bnd_s;
    logic [31:0]      count_m_s;
    logic [31:0]      limit_m_s;

    assign count_m_s = lane_merge(32'(count_q), wdata_i, wsel_i);
    assign limit_m_s = lane_merge(32'(limit_q), wdata_i, wsel_i);

    // Next count; a bus load beats a tick arriving in the same cycle
    always_comb begin
        count_d = count_q;
        bnd_s   = 1'b0;
        if (wr_count_i) begin
            count_d = count_m_s[WIDTH-1:0];
        end else if (tick_i && ctrl_q[EN_B]) begin
            if (ctrl_q[UP_B]) begin
                if (count_q < limit_q) begin
                    count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
                end else begin
                    bnd_s   = 1'b1;
                    count_d = ctrl_q[WRAP_B] ? {WIDTH{1'b0}} : count_q;
                end
            end else begin
                if (count_q != {WIDTH{1'b0}}) begin
                    count_d = count_q - {{(WIDTH-1){1'b0}}, 1'b1};
                end else begin
                    bnd_s   = 1'b1;
                    count_d = ctrl_q[WRAP_B] ? limit_q : count_q;
                end
            end
        end else begin
            count_d = count_q;
        end
    end

    // Control, limit and sticky flag updates; a new boundary event beats W1C
    always_comb begin
        ctrl_d  = ctrl_q;
        limit_d = limit_q;
        flag_d  = flag_q;
        if (wr_ctrl_i && wsel_i[0]) begin
            ctrl_d = wdata_i[3:0];
        end else begin
            ctrl_d = ctrl_q;
        end
        if (wr_limit_i) begin
            limit_d = limit_m_s[WIDTH-1:0];
        end else begin
            limit_d = limit_q;
        end
        if (bnd_s) begin
            flag_d = 1'b1;
        end else if (wr_status_i && wsel_i[0] && wdata_i[TC_B]) begin
            flag_d = 1'b0;
        end else begin
            flag_d = flag_q;
        end
    end

    // Channel state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q  <= 4'h0;
            count_q <= {WIDTH{1'b0}};
            limit_q <= {WIDTH{1'b1}};
            flag_q  <= 1'b0;
            tc_q    <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            count_q <= count_d;
            limit_q <= limit_d;
            flag_q  <= flag_d;
            tc_q    <= bnd_s;
        end
    end

    assign ctrl_o    = ctrl_q;
    assign count_o   = count_q;
    assign limit_o   = limit_q;
    assign tc_flag_o = flag_q;
    assign tc_o      = tc_q;

endmodule

// File: rtl/wb_counter_bank.sv
// Multi-channel up/down event counter bank behind a Wishbone B4 classic slave:
// address decode, single-cycle ack, registered read mux and interrupt.
module wb_counter_bank
    import wb_counter_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NCH    = 4,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [ADDR_W-1:0] wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    input  logic [3:0]        wb_sel_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack_o,
    input  logic [NCH-1:0]    tick_i,
    output logic [NCH-1:0]    tc_o,
    output logic              irq_o
);

    localparam int CH_LSB = $clog2(CH_STRIDE);

    logic              ack_q;
    logic [31:0]       dat_q;
    logic              irq_q;
    logic              acc_s;
    logic              wr_s;
    logic [31:0]       ch_ext_s;
    logic [3:0]        ofs_s;
    logic [31:0]       rdata_s;
    logic [NCH-1:0]    flag_s;
    logic [NCH-1:0]    irqen_s;
    logic [3:0]        ctrl_a  [NCH];
    logic [WIDTH-1:0]  count_a [NCH];
    logic [WIDTH-1:0]  limit_a [NCH];
    logic              unused_s;

    // A new access is only accepted while ack is low: one access per two cycles
    assign acc_s    = wb_cyc_i & wb_stb_i & ~ack_q;
    assign wr_s     = acc_s & wb_we_i;
    assign ch_ext_s = 32'(wb_adr_i[ADDR_W-1:CH_LSB]);
    assign ofs_s    = {wb_adr_i[3:2], 2'b00};
    assign unused_s = |wb_adr_i[1:0];

    for (genvar n = 0; n < NCH; n++) begin : g_ch
        logic hit_s;
        assign hit_s      = wr_s & (ch_ext_s == 32'(n));
        assign irqen_s[n] = ctrl_a[n][IRQEN_B];

        counter_channel #(.WIDTH(WIDTH)) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .tick_i      (tick_i[n]),
            .wr_ctrl_i   (hit_s & (ofs_s == CTRL_OFS)),
            .wr_count_i  (hit_s & (ofs_s == COUNT_OFS)),
            .wr_limit_i  (hit_s & (ofs_s == LIMIT_OFS)),
            .wr_status_i (hit_s & (ofs_s == STATUS_OFS)),
            .wdata_i     (wb_dat_i),
            .wsel_i      (wb_sel_i),
            .ctrl_o      (ctrl_a[n]),
            .count_o     (count_a[n]),
            .limit_o     (limit_a[n]),
            .tc_flag_o   (flag_s[n]),
            .tc_o        (tc_o[n])
        );
    end

    // Read data for the addressed register; channels >= NCH read as zero
    always_comb begin
        rdata_s = 32'h0;
        for (int n = 0; n < NCH; n++) begin
            case (ofs_s)
                CTRL_OFS:   rdata_s = rdata_s | ((ch_ext_s == 32'(n)) ? {28'h0, ctrl_a[n]} : 32'h0);
                COUNT_OFS:  rdata_s = rdata_s | ((ch_ext_s == 32'(n)) ? 32'(count_a[n]) : 32'h0);
                LIMIT_OFS:  rdata_s = rdata_s | ((ch_ext_s == 32'(n)) ? 32'(limit_a[n]) : 32'h0);
                STATUS_OFS: rdata_s = rdata_s | ((ch_ext_s == 32'(n)) ? {31'h0, flag_s[n]} : 32'h0);
                default:    rdata_s = rdata_s;
            endcase
        end
    end

    // Bus response and interrupt registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q <= 1'b0;
            dat_q <= 32'h0;
            irq_q <= 1'b0;
        end else begin
            ack_q <= acc_s;
            dat_q <= acc_s ? rdata_s : 32'h0;
            irq_q <= |(flag_s & irqen_s);
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;
    assign irq_o    = irq_q;

endmodule
